matmul_sched: RTL and testbench
===============================

MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width (8,16,32).
REQ-002 SHALL have parameter BUS_WIDTH, default 32, operand word width (16,32,64); MAX_DIM = BUS_WIDTH/DATA_WIDTH is derived, not overridable.
REQ-003 clk_i  in  1  positive-edge clock; the block's only clock.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 start_i  in  1  level start from memory (start_bit_o); held high until done_o is taken.
REQ-006 a_i  in  MAX_DIM*BUS_WIDTH  A rows; word r = row r; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 b_i  in  MAX_DIM*BUS_WIDTH  B columns; word c = column c; element k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 dim_n_i, dim_k_i, dim_m_i  in  2 each  dimension minus one (0..3 -> 1..4).
REQ-009 a_feed_o  out  MAX_DIM*DATA_WIDTH  skewed A edge inputs, lane r = array row r.
REQ-010 b_feed_o  out  MAX_DIM*DATA_WIDTH  skewed B edge inputs, lane c = array column c.
REQ-011 pe_clr_o  out  1  clears all PE accumulators and pipeline registers.
REQ-012 pe_en_o  out  1  advances array one step.
REQ-013 done_o  out  1  one-cycle pulse, drives memory sp_write.
REQ-014 busy_o  out  1  high from LOAD through DONE.
REQ-015 err_o  out  1  sticky per operation; any dim field >= MAX_DIM.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, FEED, DONE, WAIT_CLR.
REQ-017 IDLE -> LOAD on the first edge with start_i=1; the block SHALL treat start_i as a level, not an edge.
REQ-018 LOAD (1 cycle) SHALL capture a_i, b_i and dims into internal registers.
REQ-018 (cont.) LOAD SHALL assert pe_clr_o=1 and compute L = N+K+M-2 (actual dims).
REQ-019 In LOAD, if any dim field >= MAX_DIM, err_o SHALL be set and the next state SHALL be DONE (FEED skipped).
REQ-020 FEED SHALL last exactly L cycles with pe_en_o=1; step counter s runs 0..L-1 and is sized for 3*MAX_DIM-2.
REQ-021 In FEED, lane r of a_feed_o SHALL be A[r][s-r] when r<N and 0<=s-r<K, else 0; lane c of b_feed_o SHALL be B[k=s-c][c] when c<M and 0<=s-c<K, else 0.
REQ-022 Feed outputs SHALL be registered: values for step s appear in the same cycle pe_en_o is high for step s.
REQ-023 Feed outputs SHALL be 0 in every state other than FEED.
REQ-024 DONE (1 cycle) SHALL assert done_o=1, then go to WAIT_CLR.
REQ-025 WAIT_CLR SHALL stay until start_i=0, then go to IDLE; busy_o=0 here, so no re-trigger occurs while memory clears start.
REQ-026 start_i falling during LOAD/FEED SHALL be ignored; the operation completes.
REQ-027 Captured operands SHALL be immune to a_i/b_i changes after LOAD.
REQ-028 err_o SHALL clear on entry to LOAD.
REQ-029 Start-to-done latency SHALL be L+2 cycles (LOAD + L FEED + DONE edge).

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE with counter 0 and operand registers 0.
REQ-030 (cont.) It SHALL drive all outputs to 0 in the following cycle, from any state, including mid-FEED.
REQ-031 After rst_i deasserts with start_i already high, LOAD SHALL be entered on the next edge.

Structure
REQ-032 Shared package matmul_pkg SHALL hold the state enum, MAX_DIM derivation and step-counter width constant.
REQ-033 One sub-module matmul_sched_lane SHALL be instantiated per lane (2*MAX_DIM).
REQ-033 (cont.) It SHALL compute the element select/zero for a lane from lane index, s, K and live-lane limit; the top holds the FSM and counter.

Verification
REQ-034 2x2x2 (dims 1,1,1), A rows {1,2},{3,4}, B cols {5,7},{6,8}: FEED is 4 cycles.
REQ-034 (cont.) a lane0 reads 1,2,0,0 and lane1 reads 0,3,4,0; done_o rises at cycle 6 after LOAD entry-1; reference array result {19,22},{43,50}.
REQ-035 4x4x4 all-ones: FEED=10 cycles, done_o exactly once, busy_o high 12 cycles; lanes 2,3 zero outside their windows.
REQ-036 N=2,K=3,M=4 (dims 1,2,3): a lanes 2,3 always 0; L=7; b lane3 nonzero only at s=3..5.
REQ-037 Assert rst_i at s=2 of a 4x4x4 run: next cycle all outputs 0, state IDLE; start_i still high restarts with LOAD.
REQ-038 Hold start_i high for 5 cycles after done_o: no second LOAD; drop start_i -> IDLE, then raise again -> new LOAD with err_o cleared.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul systolic-array feed scheduler.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DONE,
    WAIT_CLR
  } state_e;

  // Holds the last step index 3*MAX_DIM-3 for MAX_DIM up to 8 (64-bit bus, 8-bit data).
  localparam int unsigned STEP_W = 5;

  function automatic int unsigned max_dim(input int unsigned bus_w, input int unsigned data_w);
    return bus_w / data_w;
  endfunction

  function automatic logic dim_err(input logic [1:0] dim, input int unsigned mdim);
    return 32'(dim) >= mdim;
  endfunction

endpackage

// File: rtl/matmul_sched_lane.sv
// One skewed edge lane: selects element (step - LANE) of its operand word, or zero.
module matmul_sched_lane
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned LANE       = 0
) (
  input  logic [BUS_WIDTH-1:0]  word_i,
  input  logic [STEP_W-1:0]     step_i,
  input  logic [1:0]            k_last_i,
  input  logic [1:0]            lim_i,
  input  logic                  active_i,
  output logic [DATA_WIDTH-1:0] elem_o
);

  localparam int unsigned       NELEM  = BUS_WIDTH / DATA_WIDTH;
  localparam logic [STEP_W-1:0] LANE_W = STEP_W'(LANE);

  logic [STEP_W:0]   step_diff;
  logic [STEP_W:0]   lim_diff;
  logic [STEP_W-1:0] idx;
  logic              live;

  // Borrow bits stand in for "step >= LANE" and "lim >= LANE" without constant compares.
  always_comb begin
    step_diff = {1'b0, step_i} - {1'b0, LANE_W};
    lim_diff  = {1'b0, STEP_W'(lim_i)} - {1'b0, LANE_W};
    idx       = step_diff[STEP_W-1:0];
    live      = active_i && !step_diff[STEP_W] && !lim_diff[STEP_W]
                && (idx <= STEP_W'(k_last_i));
    elem_o    = '0;
    for (int unsigned k = 0; k < NELEM; k++) begin
      if (live && (idx == STEP_W'(k))) elem_o = word_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// Operand capture, step sequencing and registered skewed feeds for an NxKxM systolic multiply.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned BUS_WIDTH  = 32,
  localparam int unsigned MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [MAX_DIM*BUS_WIDTH-1:0]  a_i,
  input  logic [MAX_DIM*BUS_WIDTH-1:0]  b_i,
  input  logic [1:0]                    dim_n_i,
  input  logic [1:0]                    dim_k_i,
  input  logic [1:0]                    dim_m_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] a_feed_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] b_feed_o,
  output logic                          pe_clr_o,
  output logic                          pe_en_o,
  output logic                          done_o,
  output logic                          busy_o,
  output logic                          err_o
);

  state_e                        state_q, state_d;
  logic [STEP_W-1:0]             step_q, step_d;
  logic [STEP_W-1:0]             last_q, last_d;
  logic [MAX_DIM*BUS_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]                    dn_q, dn_d, dk_q, dk_d, dm_q, dm_d;
  logic [MAX_DIM*DATA_WIDTH-1:0] a_feed_q, a_feed_d, b_feed_q, b_feed_d;
  logic                          clr_q, clr_d, en_q, en_d, done_q, done_d;
  logic                          busy_q, busy_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    dn_d    = dn_q;
    dk_d    = dk_q;
    dm_d    = dm_q;
    err_d   = err_q;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          a_d     = a_i;
          b_d     = b_i;
          dn_d    = dim_n_i;
          dk_d    = dim_k_i;
          dm_d    = dim_m_i;
          err_d   = 1'b0;
          clr_d   = 1'b1;
        end
      end
      LOAD: begin
        if (dim_err(dn_q, MAX_DIM) || dim_err(dk_q, MAX_DIM) || dim_err(dm_q, MAX_DIM)) begin
          state_d = DONE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = FEED;
          step_d  = '0;
          en_d    = 1'b1;
          // Last step index is L-1 = N+K+M-3 in actual dims, i.e. the sum of the minus-one fields.
          last_d  = STEP_W'(dn_q) + STEP_W'(dk_q) + STEP_W'(dm_q);
        end
      end
      FEED: begin
        if (step_q == last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
          en_d   = 1'b1;
        end
      end
      DONE:     state_d = WAIT_CLR;
      WAIT_CLR: if (!start_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == FEED) || (state_d == DONE);
  end

  // Lanes see next-cycle step/enable so the registered feeds line up with pe_en_o.
  for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
    matmul_sched_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .BUS_WIDTH (BUS_WIDTH),
      .LANE      (g)
    ) u_a_lane (
      .word_i  (a_q[g*BUS_WIDTH +: BUS_WIDTH]),
      .step_i  (step_d),
      .k_last_i(dk_q),
      .lim_i   (dn_q),
      .active_i(en_d),
      .elem_o  (a_feed_d[g*DATA_WIDTH +: DATA_WIDTH])
    );
    matmul_sched_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .BUS_WIDTH (BUS_WIDTH),
      .LANE      (g)
    ) u_b_lane (
      .word_i  (b_q[g*BUS_WIDTH +: BUS_WIDTH]),
      .step_i  (step_d),
      .k_last_i(dk_q),
      .lim_i   (dm_q),
      .active_i(en_d),
      .elem_o  (b_feed_d[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      step_q   <= '0;
      last_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dn_q     <= '0;
      dk_q     <= '0;
      dm_q     <= '0;
      a_feed_q <= '0;
      b_feed_q <= '0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dn_q     <= dn_d;
      dk_q     <= dk_d;
      dm_q     <= dm_d;
      a_feed_q <= a_feed_d;
      b_feed_q <= b_feed_d;
      clr_q    <= clr_d;
      en_q     <= en_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign a_feed_o = a_feed_q;
  assign b_feed_o = b_feed_q;
  assign pe_clr_o = clr_q;
  assign pe_en_o  = en_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Scoreboard bench: queued operations checked against a matrix-level reference model.
module tb_matmul_sched;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] a_i = '0;
  logic [127:0] b_i = '0;
  logic [1:0]   dim_n_i = '0, dim_k_i = '0, dim_m_i = '0;
  logic [31:0]  a_feed_o, b_feed_o;
  logic         pe_clr_o, pe_en_o, done_o, busy_o, err_o;

  matmul_sched #(.DATA_WIDTH(8), .BUS_WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .dim_n_i (dim_n_i),
    .dim_k_i (dim_k_i),
    .dim_m_i (dim_m_i),
    .a_feed_o(a_feed_o),
    .b_feed_o(b_feed_o),
    .pe_clr_o(pe_clr_o),
    .pe_en_o (pe_en_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   n;
    logic [1:0]   k;
    logic [1:0]   m;
    logic [127:0] a;
    logic [127:0] b;
  } op_t;

  op_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  int  en_seen = 0;

  // Element e of word w in a packed 4x4 operand image.
  function automatic int unsigned el(input logic [127:0] img, input int unsigned w, input int unsigned e);
    logic [127:0] t;
    t = img >> (w * 32 + e * 8);
    return 32'(t[7:0]);
  endfunction

  // Lane l at step s carries row/column l, element s-l, inside the live window.
  function automatic logic [31:0] exp_feed(input op_t o, input int s, input bit is_b);
    logic [31:0] v;
    int lim;
    v   = '0;
    lim = is_b ? int'(o.m) : int'(o.n);
    for (int l = 0; l < 4; l++) begin
      if (l <= lim && s >= l && (s - l) <= int'(o.k))
        v[l*8 +: 8] = 8'(is_b ? el(o.b, l, s - l) : el(o.a, l, s - l));
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  op_t         cur;
  bit          active = 1'b0;
  int          step, since, busyc, len_l;
  int unsigned oa[16][4];
  int unsigned ob[16][4];
  int unsigned c_obs, c_ref;

  always @(negedge clk) begin
    if (rst_i) begin
      chk("reset_outputs", {a_feed_o, b_feed_o, pe_clr_o, pe_en_o, done_o, busy_o, err_o}, '0);
      if (active) begin
        void'(exp_q.pop_front());
        active = 1'b0;
      end
    end else begin
      if (active) begin
        since++;
        if (busy_o) busyc++;
      end
      if (pe_clr_o) begin
        chk("load_has_op", 128'(exp_q.size() > 0), 128'(1));
        chk("load_outputs", {pe_en_o, done_o, busy_o, err_o}, 4'b0010);
        if (exp_q.size() > 0) cur = exp_q[0];
        active = 1'b1;
        step   = 0;
        since  = 0;
        busyc  = 1;
      end
      if (pe_en_o) begin
        en_seen++;
        chk("en_in_op", 128'(active), 128'(1));
        if (active && step < 16) begin
          chk($sformatf("a_feed_s%0d", step), a_feed_o, exp_feed(cur, step, 1'b0));
          chk($sformatf("b_feed_s%0d", step), b_feed_o, exp_feed(cur, step, 1'b1));
          for (int l = 0; l < 4; l++) begin
            oa[step][l] = 32'(a_feed_o[l*8 +: 8]);
            ob[step][l] = 32'(b_feed_o[l*8 +: 8]);
          end
          step++;
        end
      end else begin
        chk("feed_idle_zero", {a_feed_o, b_feed_o}, '0);
      end
      if (!active) chk("idle_busy", 128'(busy_o), '0);
      if (done_o) begin
        chk("done_in_op", 128'(active), 128'(1));
        if (active) begin
          len_l = int'(cur.n) + int'(cur.k) + int'(cur.m) + 1;
          chk("feed_len", 128'(step), 128'(len_l));
          chk("latency", 128'(since), 128'(len_l + 1));
          chk("busy_len", 128'(busyc), 128'(len_l + 2));
          chk("err", 128'(err_o), '0);
          if (step == len_l) begin
            // PE(r,c) sees lane r delayed by c and lane c delayed by r.
            for (int r = 0; r <= int'(cur.n); r++)
              for (int c = 0; c <= int'(cur.m); c++) begin
                c_obs = 0;
                c_ref = 0;
                for (int t = 0; t < len_l; t++)
                  if (t >= c && t >= r) c_obs += oa[t-c][r] * ob[t-r][c];
                for (int k = 0; k <= int'(cur.k); k++)
                  c_ref += el(cur.a, r, k) * el(cur.b, c, k);
                chk($sformatf("product_%0d_%0d", r, c), 128'(c_obs), 128'(c_ref));
              end
          end
          void'(exp_q.pop_front());
          active = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  function automatic op_t rand_op();
    op_t o;
    o.n = 2'($urandom_range(0, 3));
    o.k = 2'($urandom_range(0, 3));
    o.m = 2'($urandom_range(0, 3));
    o.a = {$urandom, $urandom, $urandom, $urandom};
    o.b = {$urandom, $urandom, $urandom, $urandom};
    return o;
  endfunction

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk) #1;
      n++;
    end
    if (done_cnt == d0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done_o expected one within 200 cycles");
    end
  endtask

  task automatic run_op(input op_t o, input int hold);
    int d0;
    @(posedge clk) #1;
    a_i = o.a; b_i = o.b;
    dim_n_i = o.n; dim_k_i = o.k; dim_m_i = o.m;
    exp_q.push_back(o);
    d0 = done_cnt;
    start_i = 1'b1;
    @(posedge clk) #1;
    a_i = {$urandom, $urandom, $urandom, $urandom};
    b_i = {$urandom, $urandom, $urandom, $urandom};
    dim_n_i = 2'($urandom); dim_k_i = 2'($urandom); dim_m_i = 2'($urandom);
    wait_done(d0);
    repeat (hold) @(posedge clk) #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk) #1;
  endtask

  op_t o;
  int  n, d0, e0;

  initial begin
    repeat (3) @(posedge clk) #1;
    rst_i = 1'b0;

    // 2x2x2 worked example
    o = '0;
    o.n = 2'd1; o.k = 2'd1; o.m = 2'd1;
    o.a = {96'd0, 8'd4, 8'd3, 8'd2, 8'd1};
    o.a = {64'd0, 16'd0, 8'd4, 8'd3, 16'd0, 8'd2, 8'd1};
    o.b = {64'd0, 16'd0, 8'd8, 8'd6, 16'd0, 8'd7, 8'd5};
    run_op(o, 0);

    // 4x4x4 all ones, start held 5 cycles past done
    o.n = 2'd3; o.k = 2'd3; o.m = 2'd3;
    o.a = {16{8'd1}};
    o.b = {16{8'd1}};
    run_op(o, 5);

    // N=2, K=3, M=4 with random data
    o = rand_op();
    o.n = 2'd1; o.k = 2'd2; o.m = 2'd3;
    run_op(o, 1);

    // Reset at step 2 of a 4x4x4 run, start kept high across reset
    o = rand_op();
    o.n = 2'd3; o.k = 2'd3; o.m = 2'd3;
    @(posedge clk) #1;
    a_i = o.a; b_i = o.b;
    dim_n_i = o.n; dim_k_i = o.k; dim_m_i = o.m;
    exp_q.push_back(o);
    e0 = en_seen;
    start_i = 1'b1;
    n = 0;
    while (en_seen < e0 + 3 && n < 100) begin
      @(negedge clk) #1;
      n++;
    end
    if (en_seen < e0 + 3) begin
      total++;
      bad++;
      $display("FAIL step2_timeout: got %0d feed steps expected 3", en_seen - e0);
    end
    rst_i = 1'b1;
    repeat (2) @(posedge clk) #1;
    exp_q.push_back(o);
    d0 = done_cnt;
    rst_i = 1'b0;
    @(posedge clk) #1;
    chk("restart_load", 128'(pe_clr_o), 128'(1));
    wait_done(d0);
    start_i = 1'b0;
    repeat (2) @(posedge clk) #1;

    for (int i = 0; i < 40; i++) run_op(rand_op(), $urandom_range(0, 5));

    repeat (3) @(posedge clk) #1;
    chk("queue_drained", 128'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
